// File: rtl/div_unit_pkg.sv
// Shared encodings for the multicycle divider: FSM states, command codes and status codes.
// The multiplier uses the same command and status codes.
package div_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2,
    ST_ZERO = 2'd3
  } div_state_e;

  typedef enum logic [1:0] {
    DIV_HOLD  = 2'b00,
    DIV_START = 2'b01,
    DIV_ABORT = 2'b10,
    DIV_RSVD  = 2'b11
  } div_ctrl_e;

  typedef enum logic [1:0] {
    DIV_ST_NONE = 2'b00,
    DIV_ST_DONE = 2'b01,
    DIV_ST_DZ   = 2'b10,
    DIV_ST_RSVD = 2'b11
  } div_status_e;

endpackage

// File: rtl/div_unit_if.sv
// Command/operand/result bundle between the control unit (master) and the divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  import div_unit_pkg::*;

  div_ctrl_e          div_ctrl;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   div_hi;
  logic [WIDTH-1:0]   div_lo;
  div_status_e        div_status;

  modport master (
    output div_ctrl, dividend, divisor,
    input  div_hi, div_lo, div_status
  );

  modport slave (
    input  div_ctrl, dividend, divisor,
    output div_hi, div_lo, div_status
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// quo_i holds the not-yet-consumed dividend bits in its MSBs; quotient bits enter at the LSB.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_i < dvs_i always holds, so the shifted partial remainder fits WIDTH+1 bits
  // and trial[WIDTH] is a clean borrow flag.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_i};

  assign rem_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Multicycle signed/unsigned divider: lo = quotient, hi = remainder, one restoring step per cycle.
// Status pulses DONE after the result is registered, or DZ for a zero divisor.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0]   rem_d, quo_d;
  logic               neg_quo_q, neg_rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  div_status_e        status_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude.
  assign a_neg = SIGNED && bus.dividend[WIDTH-1];
  assign b_neg = SIGNED && bus.divisor[WIDTH-1];
  assign a_mag = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign b_mag = b_neg ? (~bus.divisor  + 1'b1) : bus.divisor;

  assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      status_q  <= DIV_ST_NONE;
    end else begin
      status_q <= DIV_ST_NONE;
      case (state_q)
        ST_IDLE: begin
          if (bus.div_ctrl == DIV_START) begin
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= '0;
            state_q   <= (bus.divisor == '0) ? ST_ZERO : ST_CALC;
          end
        end
        ST_CALC: begin
          if (bus.div_ctrl == DIV_ABORT) begin
            state_q <= ST_IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH-1)) state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          // An abort here still wins: the finished result is dropped silently.
          if (bus.div_ctrl != DIV_ABORT) begin
            lo_q     <= quo_fix;
            hi_q     <= rem_fix;
            status_q <= DIV_ST_DONE;
          end
          state_q <= ST_IDLE;
        end
        ST_ZERO: begin
          status_q <= DIV_ST_DZ;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.div_hi     = hi_q;
  assign bus.div_lo     = lo_q;
  assign bus.div_status = status_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: a signed and an unsigned instance, directed vectors,
// expected results queued at issue time and checked by per-instance monitors.
module tb_div_unit;
  import div_unit_pkg::*;

  typedef struct {
    string       nm;
    int          cyc;
    logic [1:0]  st;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t q_s[$];
  exp_t q_u[$];
  exp_t e_s, e_u;

  div_unit_if #(.WIDTH(32)) s_if ();
  div_unit_if #(.WIDTH(32)) u_if ();

  div_unit #(.WIDTH(32), .SIGNED(1'b1)) dut_s (.clock(clock), .reset(reset), .bus(s_if));
  div_unit #(.WIDTH(32), .SIGNED(1'b0)) dut_u (.clock(clock), .reset(reset), .bus(u_if));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Caller sits at a negedge; the start is accepted at the next posedge (edge E).
  task automatic do_start(input bit u, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [1:0] st,
                          input logic [31:0] hi, input logic [31:0] lo, input string nm);
    exp_t e;
    if (u) begin
      u_if.div_ctrl = DIV_START; u_if.dividend = a; u_if.divisor = b;
    end else begin
      s_if.div_ctrl = DIV_START; s_if.dividend = a; s_if.divisor = b;
    end
    if (push) begin
      e.nm  = nm;
      e.st  = st;
      e.hi  = hi;
      e.lo  = lo;
      e.cyc = cyc + 1 + ((st == 2'b10) ? 1 : 33);
      if (u) q_u.push_back(e);
      else   q_s.push_back(e);
    end
    @(negedge clock);
    if (u) begin
      u_if.div_ctrl = DIV_HOLD; u_if.dividend = ~a; u_if.divisor = ~b;
    end else begin
      s_if.div_ctrl = DIV_HOLD; s_if.dividend = ~a; s_if.divisor = ~b;
    end
  endtask

  task automatic pulse_s(input div_ctrl_e c, input logic [31:0] a, input logic [31:0] b);
    s_if.div_ctrl = c; s_if.dividend = a; s_if.divisor = b;
    @(negedge clock);
    s_if.div_ctrl = DIV_HOLD;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (s_if.div_status != DIV_ST_NONE) begin
        if (q_s.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sgn_unexpected_status: got %0d expected 0 at cycle %0d", s_if.div_status, cyc);
        end else begin
          e_s = q_s.pop_front();
          chk({e_s.nm, "_status"}, 32'(s_if.div_status), 32'(e_s.st));
          chk({e_s.nm, "_cycle"},  32'(cyc), 32'(e_s.cyc));
          chk({e_s.nm, "_hi"},     s_if.div_hi, e_s.hi);
          chk({e_s.nm, "_lo"},     s_if.div_lo, e_s.lo);
        end
      end else if (q_s.size() != 0 && q_s[0].cyc < cyc) begin
        e_s = q_s.pop_front();
        n_tests++; n_fail++;
        $display("FAIL %s_missing: got no status by cycle %0d expected pulse at %0d", e_s.nm, cyc, e_s.cyc);
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      if (u_if.div_status != DIV_ST_NONE) begin
        if (q_u.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL uns_unexpected_status: got %0d expected 0 at cycle %0d", u_if.div_status, cyc);
        end else begin
          e_u = q_u.pop_front();
          chk({e_u.nm, "_status"}, 32'(u_if.div_status), 32'(e_u.st));
          chk({e_u.nm, "_cycle"},  32'(cyc), 32'(e_u.cyc));
          chk({e_u.nm, "_hi"},     u_if.div_hi, e_u.hi);
          chk({e_u.nm, "_lo"},     u_if.div_lo, e_u.lo);
        end
      end else if (q_u.size() != 0 && q_u[0].cyc < cyc) begin
        e_u = q_u.pop_front();
        n_tests++; n_fail++;
        $display("FAIL %s_missing: got no status by cycle %0d expected pulse at %0d", e_u.nm, cyc, e_u.cyc);
      end
    end
  end

  initial begin
    cyc     = 0;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    s_if.div_ctrl = DIV_HOLD; s_if.dividend = '0; s_if.divisor = '0;
    u_if.div_ctrl = DIV_HOLD; u_if.dividend = '0; u_if.divisor = '0;
    repeat (3) @(negedge clock);
    chk("rst_s_hi", s_if.div_hi, 32'h0);
    chk("rst_s_lo", s_if.div_lo, 32'h0);
    chk("rst_s_status", 32'(s_if.div_status), 32'h0);
    chk("rst_u_hi", u_if.div_hi, 32'h0);
    chk("rst_u_lo", u_if.div_lo, 32'h0);
    chk("rst_u_status", 32'(u_if.div_status), 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // Unsigned build
    do_start(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, 2'b01, 32'd1, 32'h7FFF_FFFF, "u_max_by_2");
    repeat (33) @(negedge clock);
    do_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2'b01, 32'h8000_0000, 32'd0, "u_msb_by_max");
    repeat (33) @(negedge clock);

    // Signed build, back-to-back where possible
    do_start(1'b0, 32'd100, 32'd7, 1'b1, 2'b01, 32'd2, 32'd14, "s_100_by_7");
    repeat (33) @(negedge clock);
    do_start(1'b0, 32'd5, 32'd0, 1'b1, 2'b10, 32'd2, 32'd14, "s_div_zero");
    repeat (1) @(negedge clock);
    do_start(1'b0, 32'hFFFF_FF9C, 32'd7, 1'b1, 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFF2, "s_m100_by_7");
    repeat (33) @(negedge clock);
    do_start(1'b0, 32'd100, 32'hFFFF_FFF9, 1'b1, 2'b01, 32'd2, 32'hFFFF_FFF2, "s_100_by_m7");
    repeat (33) @(negedge clock);
    do_start(1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'd3, "s_m7_by_m2");
    repeat (33) @(negedge clock);

    // Overflow case with an ignored start issued mid-calculation
    do_start(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2'b01, 32'd0, 32'h8000_0000, "s_min_by_m1");
    repeat (4) @(negedge clock);
    pulse_s(DIV_START, 32'd1, 32'd1);
    repeat (28) @(negedge clock);

    // Abort: ignored restart at E+5, abort at E+10, no pulse must follow
    do_start(1'b0, 32'd100, 32'd7, 1'b0, 2'b00, 32'd0, 32'd0, "s_abort");
    repeat (4) @(negedge clock);
    pulse_s(DIV_START, 32'd50, 32'd3);
    repeat (4) @(negedge clock);
    pulse_s(DIV_ABORT, 32'd0, 32'd0);
    repeat (30) @(negedge clock);
    chk("abort_hold_hi", s_if.div_hi, 32'd0);
    chk("abort_hold_lo", s_if.div_lo, 32'h8000_0000);
    do_start(1'b0, 32'd9, 32'd3, 1'b1, 2'b01, 32'd0, 32'd3, "s_9_by_3");
    repeat (33) @(negedge clock);

    // Asynchronous reset in the middle of CALC
    do_start(1'b0, 32'd1000, 32'd10, 1'b0, 2'b00, 32'd0, 32'd0, "s_reset_mid");
    repeat (10) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_hi", s_if.div_hi, 32'd0);
    chk("midrst_lo", s_if.div_lo, 32'd0);
    chk("midrst_status", 32'(s_if.div_status), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_start(1'b0, 32'd1, 32'd1, 1'b1, 2'b01, 32'd0, 32'd1, "s_1_by_1");
    repeat (36) @(negedge clock);

    for (int i = 0; i < 100 && (q_s.size() != 0 || q_u.size() != 0); i++) @(negedge clock);
    if (q_s.size() != 0 || q_u.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q_s.size() + q_u.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
